// File: rtl/fb_scan_out.sv
// Framebuffer scan-out: VGA-style timing generator that reads a scaled image window from a
// synchronous BRAM and emits greyscale pixels with a fixed 3-clock pipeline latency.
module fb_scan_out #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned IMG_W     = 128,
  parameter int unsigned IMG_H     = 128,
  parameter int unsigned SCALE     = 2,
  parameter int unsigned X0        = 192,
  parameter int unsigned Y0        = 112
) (
  input  logic        V_CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  output logic [13:0] BRAM_ADDR,
  input  logic [7:0]  BRAM_DOUT,
  output logic        V_HS,
  output logic        V_VS,
  output logic        V_DE,
  output logic [7:0]  V_GREY,
  output logic        FRAME_START
);

  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW     = $clog2(HTotal + 1);
  localparam int unsigned VW     = $clog2(VTotal + 1);
  localparam int unsigned CW     = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned SW     = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [HW-1:0] HLast    = HW'(HTotal - 1);
  localparam logic [HW-1:0] HVisEnd  = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HSyncBeg = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HSyncEnd = HW'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [HW-1:0] WinXBeg  = HW'(X0);
  localparam logic [HW-1:0] WinXEnd  = HW'(X0 + IMG_W * SCALE);
  localparam logic [HW-1:0] WinXLast = HW'(X0 + IMG_W * SCALE - 1);
  localparam logic [VW-1:0] VLast    = VW'(VTotal - 1);
  localparam logic [VW-1:0] VVisEnd  = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VSyncBeg = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VSyncEnd = VW'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [VW-1:0] WinYBeg  = VW'(Y0);
  localparam logic [VW-1:0] WinYEnd  = VW'(Y0 + IMG_H * SCALE);
  localparam logic [SW-1:0] SubLast  = SW'(SCALE - 1);
  localparam logic [13:0]   RowStep  = 14'(IMG_W);

  if (IMG_W * IMG_H > 16384) begin : g_bad_image_size
    $error("fb_scan_out: IMG_W*IMG_H exceeds the 14-bit frame-buffer address space");
  end
  if (SCALE == 0 || IMG_W == 0 || IMG_H == 0 ||
      X0 + IMG_W * SCALE > H_VISIBLE || Y0 + IMG_H * SCALE > V_VISIBLE) begin : g_bad_window
    $error("fb_scan_out: image window does not fit inside the visible area");
  end

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [CW-1:0] col_q, col_d;
  logic [SW-1:0] hsub_q, hsub_d, vsub_q, vsub_d;
  logic [13:0]   row_q, row_d, addr_q, addr_d;
  logic          in_win_x, in_win_y, in_win, vis, hs_act, vs_act, origin;
  logic          de1_q, hs1_q, vs1_q, fs1_q, show1_q;
  logic          de2_q, hs2_q, vs2_q, fs2_q, show2_q;

  always_comb begin
    h_d = h_q + HW'(1);
    v_d = v_q;
    if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + VW'(1);
    end
  end

  always_comb begin
    in_win_x = (h_q >= WinXBeg) && (h_q < WinXEnd);
    in_win_y = (v_q >= WinYBeg) && (v_q < WinYEnd);
    in_win   = in_win_x && in_win_y;
    vis      = (h_q < HVisEnd) && (v_q < VVisEnd);
    hs_act   = (h_q >= HSyncBeg) && (h_q < HSyncEnd);
    vs_act   = (v_q >= VSyncBeg) && (v_q < VSyncEnd);
    origin   = (h_q == '0) && (v_q == '0);
  end

  // Column counter idles at zero outside the window so it is primed for the next row.
  always_comb begin
    col_d  = '0;
    hsub_d = '0;
    if (in_win && (h_q != WinXLast)) begin
      if (hsub_q == SubLast) begin
        col_d = col_q + CW'(1);
      end else begin
        col_d  = col_q;
        hsub_d = hsub_q + SW'(1);
      end
    end
  end

  always_comb begin
    row_d  = row_q;
    vsub_d = vsub_q;
    if (h_q == HLast) begin
      if (v_q == VLast) begin
        row_d  = '0;
        vsub_d = '0;
      end else if (in_win_y) begin
        if (vsub_q == SubLast) begin
          vsub_d = '0;
          row_d  = row_q + RowStep;
        end else begin
          vsub_d = vsub_q + SW'(1);
        end
      end
    end
    addr_d = in_win ? row_q + 14'(col_q) : addr_q;
  end

  always_ff @(posedge V_CLK) begin
    if (RESET) begin
      h_q         <= '0;
      v_q         <= '0;
      col_q       <= '0;
      hsub_q      <= '0;
      vsub_q      <= '0;
      row_q       <= '0;
      addr_q      <= '0;
      de1_q       <= 1'b0;
      hs1_q       <= 1'b0;
      vs1_q       <= 1'b0;
      fs1_q       <= 1'b0;
      show1_q     <= 1'b0;
      de2_q       <= 1'b0;
      hs2_q       <= 1'b0;
      vs2_q       <= 1'b0;
      fs2_q       <= 1'b0;
      show2_q     <= 1'b0;
      V_HS        <= 1'b1;
      V_VS        <= 1'b1;
      V_DE        <= 1'b0;
      V_GREY      <= '0;
      FRAME_START <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      col_q       <= col_d;
      hsub_q      <= hsub_d;
      vsub_q      <= vsub_d;
      row_q       <= row_d;
      // Stage 1: address issued alongside the decoded position flags.
      addr_q      <= addr_d;
      de1_q       <= vis;
      hs1_q       <= hs_act;
      vs1_q       <= vs_act;
      fs1_q       <= origin;
      show1_q     <= vis && in_win && ENABLE;
      // Stage 2: wait for the BRAM read data.
      de2_q       <= de1_q;
      hs2_q       <= hs1_q;
      vs2_q       <= vs1_q;
      fs2_q       <= fs1_q;
      show2_q     <= show1_q;
      // Stage 3: registered outputs.
      V_HS        <= ~hs2_q;
      V_VS        <= ~vs2_q;
      V_DE        <= de2_q;
      V_GREY      <= show2_q ? BRAM_DOUT : 8'h00;
      FRAME_START <= fs2_q;
    end
  end

  assign BRAM_ADDR = addr_q;

endmodule

// File: tb/tb_fb_scan_out.sv
// Scoreboard bench for fb_scan_out on a shrunken raster (56x37 total, 8x6 image, scale 3)
// so several frames fit in a short run. Position (h,v) in a frame is index v*56+h.
module tb_fb_scan_out;

  localparam int unsigned Frame = 56 * 37;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [13:0] bram_addr;
  logic [7:0]  bram_dout = 8'h00;
  logic        v_hs, v_vs, v_de, fs;
  logic [7:0]  v_grey;

  fb_scan_out #(
    .H_VISIBLE(40), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_VISIBLE(30), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .IMG_W(8), .IMG_H(6), .SCALE(3), .X0(10), .Y0(5)
  ) dut (
    .V_CLK      (clk),
    .RESET      (rst),
    .ENABLE     (en),
    .BRAM_ADDR  (bram_addr),
    .BRAM_DOUT  (bram_dout),
    .V_HS       (v_hs),
    .V_VS       (v_vs),
    .V_DE       (v_de),
    .V_GREY     (v_grey),
    .FRAME_START(fs)
  );

  always #5 clk = ~clk;

  // Synchronous BRAM model; top bit flipped so address 0 is not mistaken for black.
  always @(posedge clk) bram_dout <= bram_addr[7:0] ^ 8'h80;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned due;
    bit          is_out;
    logic [13:0] addr;
    logic [11:0] out;    // {hs, vs, de, grey[7:0], fs}
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned base = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  localparam logic [11:0] RstOut = {1'b1, 1'b1, 1'b0, 8'h00, 1'b0};

  task automatic push(input string name, input int unsigned due, input bit is_out,
                      input logic [13:0] addr, input logic [11:0] out);
    exp_t e;
    e.due = due; e.is_out = is_out; e.addr = addr; e.out = out; e.name = name;
    sb.push_back(e);
  endtask

  task automatic exp_out(input string name, input int unsigned pos, input bit hs, input bit vs,
                         input bit de, input logic [7:0] grey, input bit f);
    push(name, base + pos + 3, 1'b1, 14'd0, {hs, vs, de, grey, f});
  endtask

  task automatic exp_addr(input string name, input int unsigned pos, input logic [13:0] addr);
    push(name, base + pos + 1, 1'b0, addr, 12'd0);
  endtask

  task automatic wait_pos(input int unsigned p);
    while (cyc - base < p) @(negedge clk);
  endtask

  // Monitor: compare every expectation that falls due on this cycle.
  always @(negedge clk) begin
    logic [11:0] act;
    logic [11:0] want;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        n_checks++;
        if (sb[i].is_out) begin
          act  = {v_hs, v_vs, v_de, v_grey, fs};
          want = sb[i].out;
          if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got hs=%b vs=%b de=%b grey=%02h fs=%b, expected hs=%b vs=%b de=%b grey=%02h fs=%b",
                     sb[i].name, act[11], act[10], act[9], act[8:1], act[0],
                     want[11], want[10], want[9], want[8:1], want[0]);
          end
        end else if (bram_addr !== sb[i].addr) begin
          n_fail++;
          $display("FAIL %s: got BRAM_ADDR=%0d, expected %0d", sb[i].name, bram_addr, sb[i].addr);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: check due at cycle %0d was missed", sb[i].name, sb[i].due);
        sb.delete(i);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    @(negedge clk);
    push("rst_out_a", cyc + 1, 1'b1, 14'd0, RstOut);
    push("rst_addr_a", cyc + 1, 1'b0, 14'd0, 12'd0);
    push("rst_out_b", cyc + 2, 1'b1, 14'd0, RstOut);
    repeat (3) @(negedge clk);
    base = cyc;
    rst  = 1'b0;

    // Frame 0: timing, syncs, window addressing and grey.
    exp_out("fs_origin",     0,    1, 1, 1, 8'h00, 1);
    exp_out("fs_next",       1,    1, 1, 1, 8'h00, 0);
    exp_out("de_last",       39,   1, 1, 1, 8'h00, 0);
    exp_out("de_off",        40,   1, 1, 0, 8'h00, 0);
    exp_out("hs_pre",        43,   1, 1, 0, 8'h00, 0);
    exp_out("hs_first",      44,   0, 1, 0, 8'h00, 0);
    exp_out("hs_last",       49,   0, 1, 0, 8'h00, 0);
    exp_out("hs_post",       50,   1, 1, 0, 8'h00, 0);
    exp_out("win_left_out",  289,  1, 1, 1, 8'h00, 0);
    exp_out("win_origin",    290,  1, 1, 1, 8'h80, 0);
    exp_out("win_sub2",      292,  1, 1, 1, 8'h80, 0);
    exp_out("win_col1",      293,  1, 1, 1, 8'h81, 0);
    exp_out("win_row0_last", 402,  1, 1, 1, 8'h80, 0);
    exp_out("win_row1",      458,  1, 1, 1, 8'h88, 0);
    exp_out("win_far",       1265, 1, 1, 1, 8'hAF, 0);
    exp_out("win_right_out", 1266, 1, 1, 1, 8'h00, 0);
    exp_out("win_below",     1298, 1, 1, 1, 8'h00, 0);
    exp_out("vs_pre",        1736, 1, 1, 0, 8'h00, 0);
    exp_out("vs_first",      1792, 1, 0, 0, 8'h00, 0);
    exp_out("vs_hs",         1837, 0, 0, 0, 8'h00, 0);
    exp_out("vs_last",       1903, 1, 0, 0, 8'h00, 0);
    exp_out("vs_post",       1904, 1, 1, 0, 8'h00, 0);
    exp_out("fs_prev",       2071, 1, 1, 0, 8'h00, 0);
    exp_addr("addr_origin",     290,  14'd0);
    exp_addr("addr_sub1",       291,  14'd0);
    exp_addr("addr_col1",       293,  14'd1);
    exp_addr("addr_hold_left",  345,  14'd7);
    exp_addr("addr_row1",       458,  14'd8);
    exp_addr("addr_row_mid",    748,  14'd19);
    exp_addr("addr_far",        1265, 14'd47);
    exp_addr("addr_hold_right", 1266, 14'd47);
    exp_addr("addr_hold_frame", 2072, 14'd47);

    // Frame 1: ENABLE low for the whole frame.
    exp_out("en0_fs",  Frame,        1, 1, 1, 8'h00, 1);
    exp_out("en0_hs",  Frame + 44,   0, 1, 0, 8'h00, 0);
    exp_out("en0_win", Frame + 290,  1, 1, 1, 8'h00, 0);
    exp_out("en0_far", Frame + 1265, 1, 1, 1, 8'h00, 0);
    exp_out("en0_vs",  Frame + 1792, 1, 0, 0, 8'h00, 0);
    exp_addr("en0_addr", Frame + 293, 14'd1);
    wait_pos(Frame);
    en = 1'b0;

    // Frame 2: ENABLE raised at (20,8).
    wait_pos(2 * Frame);
    exp_out("fs_frame2",   2 * Frame,       1, 1, 1, 8'h00, 1);
    exp_out("en_still0",   2 * Frame + 467, 1, 1, 1, 8'h00, 0);
    exp_out("en_resume",   2 * Frame + 468, 1, 1, 1, 8'h8B, 0);
    exp_out("en_next_row", 2 * Frame + 514, 1, 1, 1, 8'h88, 0);
    wait_pos(2 * Frame + 468);
    en = 1'b1;

    // One-clock reset pulse at (46,15), inside the hsync pulse.
    wait_pos(2 * Frame + 886);
    rst = 1'b1;
    push("rst_mid_out", cyc + 1, 1'b1, 14'd0, RstOut);
    push("rst_mid_addr", cyc + 1, 1'b0, 14'd0, 12'd0);
    @(negedge clk);
    rst  = 1'b0;
    base = cyc;
    push("re_flush1", base + 1, 1'b1, 14'd0, RstOut);
    push("re_flush2", base + 2, 1'b1, 14'd0, RstOut);
    exp_out("re_fs",     0,   1, 1, 1, 8'h00, 1);
    exp_out("re_hs_pre", 43,  1, 1, 0, 8'h00, 0);
    exp_out("re_hs",     44,  0, 1, 0, 8'h00, 0);
    exp_out("re_grey",   293, 1, 1, 1, 8'h81, 0);
    exp_addr("re_addr0", 0,   14'd0);
    exp_addr("re_addr",  293, 14'd1);

    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
    foreach (sb[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: check never evaluated (due cycle %0d)", sb[i].name, sb[i].due);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_scan_out.md
FB_SCAN_OUT -- requirements
Module: fb_scan_out

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- H_VISIBLE 640: visible pixels per line.
- H_FP 16: horizontal front porch, clocks.
- H_SYNC 96: horizontal sync width, clocks.
- H_BP 48: horizontal back porch, clocks.
- V_VISIBLE 480: visible lines per frame.
- V_FP 10: vertical front porch, lines.
- V_SYNC 2: vertical sync width, lines.
- V_BP 33: vertical back porch, lines.
- IMG_W 128: source image width, pixels.
- IMG_H 128: source image height, lines.
- SCALE 2: integer pixel/line replication factor.
- X0 192: window left edge, output pixels.
- Y0 112: window top edge, output lines.
REQ-002 Ports, one per line (name, direction, width, meaning):
- V_CLK in 1: pixel clock, the block's only clock.
- RESET in 1: synchronous, active-high reset.
- ENABLE in 1: high = show image, low = force black.
- BRAM_ADDR out 14: frame-buffer read address.
- BRAM_DOUT in 8: frame-buffer read data, valid 1 clock after BRAM_ADDR.
- V_HS out 1: horizontal sync, active low.
- V_VS out 1: vertical sync, active low.
- V_DE out 1: visible-area flag.
- V_GREY out 8: greyscale pixel.
- FRAME_START out 1: 1-clock pulse marking the first pixel of each frame.
REQ-003 The block SHALL have one clock (V_CLK) and a synchronous, active-high reset (RESET).

Function
REQ-004 H_CNT SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 800) and wrap to 0.
REQ-005 V_CNT SHALL increment when H_CNT wraps, count 0..V_TOTAL-1 (525) and wrap to 0.
REQ-006 Visible area SHALL be H_CNT<H_VISIBLE and V_CNT<V_VISIBLE.
REQ-007 HS SHALL be active for H_VISIBLE+H_FP <= H_CNT < H_VISIBLE+H_FP+H_SYNC.
REQ-008 VS SHALL be active for V_VISIBLE+V_FP <= V_CNT < V_VISIBLE+V_FP+V_SYNC.
REQ-009 Window SHALL be X0 <= H_CNT < X0+IMG_W*SCALE and Y0 <= V_CNT < Y0+IMG_H*SCALE.
REQ-010 In window, the source pixel SHALL be sx=(H_CNT-X0)/SCALE, sy=(V_CNT-Y0)/SCALE.
REQ-011 In window, BRAM_ADDR SHALL equal sy*IMG_W+sx.
REQ-012 Address generation SHALL use a column counter and a row-base register with SCALE sub-counters; no multiplier or divider.
REQ-013 The row base SHALL advance by IMG_W after every SCALE window lines and clear to 0 at V_CNT=0.
REQ-014 Outside the window, BRAM_ADDR SHALL hold its last value.
REQ-015 Pipeline: BRAM_ADDR registered 1 clock after the counter value, BRAM_DOUT sampled 1 clock later, outputs registered 1 clock later.
REQ-016 All of V_HS, V_VS, V_DE, V_GREY and FRAME_START for position (h,v) SHALL appear exactly 3 clocks after H_CNT=h, V_CNT=v.
REQ-017 V_GREY SHALL equal BRAM_DOUT only when the position is visible, in window and ENABLE=1; otherwise 0.
REQ-018 ENABLE SHALL be sampled with the counter stage and SHALL NOT affect timing, syncs or BRAM_ADDR.
REQ-019 FRAME_START SHALL be high for one clock, aligned with position (0,0).
REQ-020 Parameters SHALL satisfy IMG_W*IMG_H <= 16384 and the window SHALL lie inside the visible area; violation is an elaboration error.

Reset
REQ-021 RESET SHALL clear H_CNT, V_CNT, the row base, the column counter, all sub-counters and the pipeline on the next V_CLK edge.
REQ-022 Reset output values SHALL be BRAM_ADDR=0, V_HS=1, V_VS=1, V_DE=0, V_GREY=0, FRAME_START=0.
REQ-023 Reset asserted mid-frame SHALL restart counting at (0,0) on the clock after release, with no partial sync pulse emitted.
REQ-024 After release, the first FRAME_START SHALL occur 3 clocks after counting resumes.

Verification
REQ-025 Reset held 4 clocks then released -> reset values per REQ-022; V_HS low first at clock 659 after release, for 96 clocks.
REQ-026 Free run -> FRAME_START period 420000 clocks; V_VS low for 1600 clocks starting at line 490.
REQ-027 BRAM model returns addr[7:0] -> BRAM_ADDR 0 at (192,112) and (193,112), 1 at (194,112), 128 at (192,114), 16383 at (447,367); V_GREY matches 3 clocks later.
REQ-028 Positions (191,112) and (448,112) -> V_DE=1, V_GREY=0.
REQ-029 ENABLE low for one full frame -> V_GREY=0 throughout with syncs and DE unchanged; ENABLE raised mid-line -> image resumes 3 clocks later.
REQ-030 RESET pulsed at (300,200) -> outputs at reset values next clock; after release, counting restarts from (0,0).
